// File: rtl/lamp_state_encoder.sv
// Recovers the active-light count from a thermometer-coded lamp status vector by scanning a
// snapshot one bit per clock, LSB first, and flags non-thermometer codes and count overflow.
module lamp_state_encoder #(
    parameter int unsigned NUM_LIGHTS = 16,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_LIGHTS-1:0] lights_state,
    output logic                  busy,
    output logic [CNT_W-1:0]      active_lights,
    output logic                  thermo_err,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned IDX_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam int unsigned CNT_IW = CNT_W + 1;
    localparam logic [CNT_IW-1:0] CNT_MAX  = CNT_IW'((1 << CNT_W) - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_LIGHTS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                state;
    logic [NUM_LIGHTS-1:0] snap;
    logic [IDX_W-1:0]      idx;
    logic [CNT_IW-1:0]     cnt;
    logic                  seen_zero;
    logic                  err;

    logic                  cur_bit;
    logic [CNT_IW-1:0]     cnt_next;
    logic                  err_next;

    // Count and error including the bit under examination, so the last bit can feed the
    // registered result in the same edge that enters DONE.
    always_comb begin
        cur_bit  = snap[idx];
        cnt_next = cnt + CNT_IW'(cur_bit);
        err_next = err | (cur_bit & seen_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= StIdle;
            snap          <= '0;
            idx           <= '0;
            cnt           <= '0;
            seen_zero     <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            active_lights <= '0;
            thermo_err    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        snap      <= lights_state;
                        idx       <= '0;
                        cnt       <= '0;
                        seen_zero <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StScan;
                    end
                end
                StScan: begin
                    cnt <= cnt_next;
                    err <= err_next;
                    if (!cur_bit) begin
                        seen_zero <= 1'b1;
                    end
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state         <= StDone;
                        out_valid     <= 1'b1;
                        overflow      <= (cnt_next > CNT_MAX);
                        thermo_err    <= err_next;
                        active_lights <= (cnt_next > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                              : cnt_next[CNT_W-1:0];
                    end
                end
                StDone: begin
                    // Result fields are left as-is so they remain readable after the handshake.
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_state_encoder.sv
// Directed bench for lamp_state_encoder: a phase-level reference model checked every cycle,
// plus literal expectations for each directed vector.
module tb_lamp_state_encoder;

    localparam int unsigned NL = 16;
    localparam int unsigned CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [NL-1:0] lights_state = '0;
    logic          busy;
    logic [CW-1:0] active_lights;
    logic          thermo_err;
    logic          overflow;
    logic          out_valid;

    lamp_state_encoder #(
        .NUM_LIGHTS(NL),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .lights_state (lights_state),
        .busy         (busy),
        .active_lights(active_lights),
        .thermo_err   (thermo_err),
        .overflow     (overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popcount(input logic [NL-1:0] v);
        int n = 0;
        for (int i = 0; i < NL; i++) n += int'(v[i]);
        return n;
    endfunction

    // A legal code is 2^k-1, i.e. v & (v+1) == 0.
    function automatic bit not_thermo(input logic [NL-1:0] v);
        logic [NL:0] w;
        w = {1'b0, v} + (NL+1)'(1);
        return (({1'b0, v} & w) != '0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: idle -> NL scan cycles -> waiting for handshake.
    int            m_phase = 0;
    int            m_left = 0;
    logic [NL-1:0] m_snap = '0;
    int            m_busy = 0, m_valid = 0, m_al = 0, m_te = 0, m_ov = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_snap <= '0;
            m_busy <= 0; m_valid <= 0; m_al <= 0; m_te <= 0; m_ov <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_snap <= lights_state; m_left <= NL - 1; m_phase <= 1; m_busy <= 1;
                end
                1: if (m_left == 0) begin
                    m_phase <= 2;
                    m_valid <= 1;
                    m_al    <= (popcount(m_snap) > MAXC) ? MAXC : popcount(m_snap);
                    m_ov    <= int'(popcount(m_snap) > MAXC);
                    m_te    <= int'(not_thermo(m_snap));
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) begin
                    m_phase <= 0; m_valid <= 0; m_busy <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", int'(busy), m_busy);
            check("model_valid", int'(out_valid), m_valid);
            check("model_active_lights", int'(active_lights), m_al);
            check("model_thermo_err", int'(thermo_err), m_te);
            check("model_overflow", int'(overflow), m_ov);
        end
    end

    // Called right after a negedge with the DUT idle; returns at the first negedge with valid.
    task automatic scan(input logic [NL-1:0] vec, input bit ready, input bit poke,
                        output int vcyc);
        int k = 0;
        bit got = 1'b0;
        lights_state = vec;
        start = 1'b1;
        out_ready = ready;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (poke && k == 5) begin
                start = 1'b1;
                lights_state = 16'hFFFF;
            end
            if (poke && k == 6) start = 1'b0;
            if (k < 17) check("busy_during_scan", int'(busy), 1);
            if (out_valid) got = 1'b1;
        end
        check("valid_latency", k, 17);
        vcyc = cyc;
    endtask

    task automatic expect_result(input string name, input int al, input int te, input int ov);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_busy"}, int'(busy), 1);
        check({name, "_active_lights"}, int'(active_lights), al);
        check({name, "_thermo_err"}, int'(thermo_err), te);
        check({name, "_overflow"}, int'(overflow), ov);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v1, v2;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_active_lights", int'(active_lights), 0);
        rst_n = 1'b1;
        @(negedge clk);

        scan(16'h0000, 1'b1, 1'b0, v1);
        expect_result("zero", 0, 0, 0);
        @(negedge clk);
        check("zero_valid_drop", int'(out_valid), 0);
        check("zero_busy_drop", int'(busy), 0);

        scan(16'h007F, 1'b1, 1'b0, v1);
        expect_result("x007f", 7, 0, 0);
        @(negedge clk);
        scan(16'h7FFF, 1'b1, 1'b0, v2);
        expect_result("x7fff", 15, 0, 0);
        check("back_to_back_period", v2 - v1, 18);
        @(negedge clk);

        scan(16'hFFFF, 1'b1, 1'b0, v1);
        expect_result("xffff", 15, 0, 1);
        @(negedge clk);

        scan(16'h00F5, 1'b1, 1'b0, v1);
        expect_result("x00f5", 6, 1, 0);
        @(negedge clk);

        scan(16'h0003, 1'b1, 1'b1, v1);
        expect_result("snapshot_0003", 2, 0, 0);
        @(negedge clk);

        scan(16'h000F, 1'b0, 1'b0, v1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i == 2);
            expect_result("hold", 4, 0, 0);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        check("handshake_valid_drop", int'(out_valid), 0);
        check("handshake_busy_drop", int'(busy), 0);
        check("handshake_keep_count", int'(active_lights), 4);
        @(negedge clk);
        check("start_in_handshake_ignored", int'(busy), 0);

        lights_state = 16'h0001;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_active_lights", int'(active_lights), 0);
        rst_n = 1'b1;
        @(negedge clk);
        scan(16'h0001, 1'b1, 1'b0, v1);
        expect_result("after_reset", 1, 0, 0);
        @(negedge clk);

        scan(16'h0002, 1'b1, 1'b0, v1);
        expect_result("x0002", 1, 1, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
